// File: rtl/sdram_burst_arbiter_if.sv
// Signals between sdram_burst_arbiter, its two requesting ports and the sdram_top burst interface.
// The master modport is the arbiter's view; slave is the view of the requesters and sdram_top.
interface sdram_burst_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [22:0] p0_addr;
    logic [8:0]  p0_len;
    logic [15:0] p0_wdata;
    logic        p0_ack;
    logic [15:0] p0_rdata;
    logic        p0_done;

    logic        p1_req;
    logic        p1_we;
    logic [22:0] p1_addr;
    logic [8:0]  p1_len;
    logic [15:0] p1_wdata;
    logic        p1_ack;
    logic [15:0] p1_rdata;
    logic        p1_done;

    logic        sdram_init_done;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic [22:0] sys_wraddr;
    logic [22:0] sys_rdaddr;
    logic [8:0]  sdwr_byte;
    logic [8:0]  sdrd_byte;
    logic [15:0] sys_data_in;
    logic [15:0] sys_data_out;

    modport master (
        input  p0_req, p0_we, p0_addr, p0_len, p0_wdata,
        output p0_ack, p0_rdata, p0_done,
        input  p1_req, p1_we, p1_addr, p1_len, p1_wdata,
        output p1_ack, p1_rdata, p1_done,
        input  sdram_init_done, sdram_wr_ack, sdram_rd_ack, sys_data_out,
        output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
        output sdwr_byte, sdrd_byte, sys_data_in
    );

    modport slave (
        output p0_req, p0_we, p0_addr, p0_len, p0_wdata,
        input  p0_ack, p0_rdata, p0_done,
        output p1_req, p1_we, p1_addr, p1_len, p1_wdata,
        input  p1_ack, p1_rdata, p1_done,
        output sdram_init_done, sdram_wr_ack, sdram_rd_ack, sys_data_out,
        input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
        input  sdwr_byte, sdrd_byte, sys_data_in
    );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Two-port round-robin burst arbiter in front of sdram_top: one whole read or write burst
// per grant, per-word ack routing, and an abort if the controller never acks the command.
module sdram_burst_arbiter #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int TW          = 10
) (
    input  logic                          clk,
    input  logic                          reset_n,
    sdram_burst_arbiter_if.master         bus,
    output logic [1:0]                    grant,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_XFER = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    logic [2:0]    state;
    logic          last_grant;
    logic          we_r;
    logic [22:0]   addr_r;
    logic [8:0]    len_r;
    logic [8:0]    count;
    logic [TW-1:0] tcnt;
    logic          wr_req_r;
    logic          rd_req_r;

    logic          pick_p1;
    logic          sel_we;
    logic [22:0]   sel_addr;
    logic [8:0]    sel_len;
    logic          match_ack;
    logic          in_xfer;

    // On a tie the port that did not own the previous burst wins.
    always_comb begin
        pick_p1   = (bus.p0_req && bus.p1_req) ? ~last_grant : bus.p1_req;
        sel_we    = pick_p1 ? bus.p1_we   : bus.p0_we;
        sel_addr  = pick_p1 ? bus.p1_addr : bus.p0_addr;
        sel_len   = pick_p1 ? bus.p1_len  : bus.p0_len;
        match_ack = we_r ? bus.sdram_wr_ack : bus.sdram_rd_ack;
        in_xfer   = (state == S_REQ) || (state == S_XFER);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_INIT;
            last_grant  <= 1'b1;
            grant       <= 2'b00;
            we_r        <= 1'b0;
            addr_r      <= '0;
            len_r       <= '0;
            count       <= '0;
            tcnt        <= '0;
            wr_req_r    <= 1'b0;
            rd_req_r    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_INIT: begin
                    if (bus.sdram_init_done) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!bus.sdram_init_done) begin
                        state <= S_INIT;
                    end else if (bus.p0_req || bus.p1_req) begin
                        grant  <= pick_p1 ? 2'b10 : 2'b01;
                        we_r   <= sel_we;
                        addr_r <= sel_addr;
                        len_r  <= sel_len;
                        count  <= '0;
                        tcnt   <= '0;
                        if (sel_len == 9'd0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_REQ;
                            wr_req_r <= sel_we;
                            rd_req_r <= ~sel_we;
                        end
                    end
                end
                // Only the wait for the first ack is bounded; once data flows the controller owns pacing.
                S_REQ: begin
                    if (match_ack) begin
                        wr_req_r <= 1'b0;
                        rd_req_r <= 1'b0;
                        count    <= 9'd1;
                        state    <= (len_r == 9'd1) ? S_DONE : S_XFER;
                    end else if (tcnt == T_LAST) begin
                        wr_req_r    <= 1'b0;
                        rd_req_r    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_XFER: begin
                    if (match_ack) begin
                        count <= count + 9'd1;
                        if (count == len_r - 9'd1) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_grant <= grant[1];
                    grant      <= 2'b00;
                    state      <= bus.sdram_init_done ? S_IDLE : S_INIT;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign busy = in_xfer || (state == S_DONE);

    assign bus.sdram_wr_req = wr_req_r;
    assign bus.sdram_rd_req = rd_req_r;
    assign bus.sys_wraddr   = addr_r;
    assign bus.sys_rdaddr   = addr_r;
    assign bus.sdwr_byte    = len_r;
    assign bus.sdrd_byte    = len_r;

    // Data and strobes are steered purely by grant so an idle port never sees traffic.
    assign bus.sys_data_in = grant[0] ? bus.p0_wdata :
                             grant[1] ? bus.p1_wdata : 16'h0000;

    assign bus.p0_ack   = match_ack & grant[0] & in_xfer;
    assign bus.p1_ack   = match_ack & grant[1] & in_xfer;
    assign bus.p0_rdata = grant[0] ? bus.sys_data_out : 16'h0000;
    assign bus.p1_rdata = grant[1] ? bus.sys_data_out : 16'h0000;
    assign bus.p0_done  = (state == S_DONE) & grant[0];
    assign bus.p1_done  = (state == S_DONE) & grant[1];

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter: a table of single-port bursts plus
// hand-written sequences for init gating, round-robin, ack timeout and mid-burst reset.
module tb_sdram_burst_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_err;

    int compared   = 0;
    int mismatched = 0;

    sdram_burst_arbiter_if bus();

    sdram_burst_arbiter #(.ACK_TIMEOUT(1024), .TW(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          we;
        logic [22:0] addr;
        logic [8:0]  len;
        logic [15:0] base;
        logic [1:0]  exp_grant;
        int          exp_acks;
        bit          exp_cmd;
        int          exp_done_cyc;
    } vec_t;

    typedef struct {
        int          acks_seen;
        int          done_cnt;
        int          done_cyc;
        int          errs;
        logic [1:0]  g_seen;
        logic        cmd_seen;
        logic [22:0] addr_seen;
        logic [8:0]  len_seen;
        logic [1:0]  grant_after;
        logic        busy_after;
        logic        done_after;
    } res_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_len = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_len = '0; bus.p1_wdata = '0;
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0; bus.sys_data_out = '0;
    endtask

    task automatic setPort(input bit port, input logic req, input logic we, input logic [22:0] addr,
                           input logic [8:0] len, input logic [15:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_len = len; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_len = len; bus.p0_wdata = wdata;
        end
    endtask

    // Leaves the bench at a falling edge with the DUT in IDLE (init) or INIT (no init).
    task automatic doReset(input logic init);
        @(negedge clk);
        reset_n = 1'b0;
        clearInputs();
        bus.sdram_init_done = init;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        if (init) @(negedge clk);
    endtask

    // Plays one burst from a single port, acting as sdram_top: acks every cycle once the command is up.
    task automatic applyStimulus(input vec_t v, output res_t r);
        int          given;
        logic        ack_now, pa, oa, pd, od;
        logic [15:0] word, prd, ord;
        r.acks_seen = 0; r.done_cnt = 0; r.done_cyc = -1; r.errs = 0;
        r.g_seen = 2'b00; r.cmd_seen = 1'b0; r.addr_seen = '0; r.len_seen = '0;
        given = 0;
        @(negedge clk);
        setPort(v.port, 1'b1, v.we, v.addr, v.len, v.base);
        setPort(!v.port, 1'b0, 1'b0, 23'd0, 9'd0, 16'hDEAD);
        for (int cyc = 0; cyc < int'(v.len) + 10; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if ((bus.sdram_wr_req && !v.we) || (bus.sdram_rd_req && v.we)) r.errs++;
            if ((bus.sdram_wr_req || bus.sdram_rd_req) && !r.cmd_seen) begin
                r.cmd_seen  = 1'b1;
                r.addr_seen = v.we ? bus.sys_wraddr : bus.sys_rdaddr;
                r.len_seen  = v.we ? bus.sdwr_byte  : bus.sdrd_byte;
            end
            word    = v.base + 16'(given);
            ack_now = r.cmd_seen && (given < int'(v.len));
            bus.sdram_wr_ack = ack_now && v.we;
            bus.sdram_rd_ack = ack_now && !v.we;
            bus.sys_data_out = v.we ? 16'h0000 : word;
            if (v.port) bus.p1_wdata = word; else bus.p0_wdata = word;
            #1;
            pa  = v.port ? bus.p1_ack   : bus.p0_ack;
            oa  = v.port ? bus.p0_ack   : bus.p1_ack;
            pd  = v.port ? bus.p1_done  : bus.p0_done;
            od  = v.port ? bus.p0_done  : bus.p1_done;
            prd = v.port ? bus.p1_rdata : bus.p0_rdata;
            ord = v.port ? bus.p0_rdata : bus.p1_rdata;
            if (pa !== ack_now) r.errs++;
            if (pa) begin
                r.acks_seen++;
                if (v.we && bus.sys_data_in !== word) r.errs++;
                if (!v.we && prd !== word) r.errs++;
            end
            if (oa || od || timeout_err || ord !== 16'h0000) r.errs++;
            if (grant != 2'b00) r.g_seen = grant;
            if (ack_now) given++;
            if (pd) begin
                r.done_cnt++;
                r.done_cyc = cyc;
                setPort(v.port, 1'b0, v.we, v.addr, v.len, word);
                break;
            end
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
        @(negedge clk);
        #1;
        r.grant_after = grant;
        r.busy_after  = busy;
        r.done_after  = bus.p0_done | bus.p1_done;
    endtask

    initial begin
        res_t       r;
        int         viol, hi, n, given;
        logic [1:0] rr [4];
        logic [1:0] exp_rr [4];

        vecs[0] = '{port:1'b0, we:1'b1, addr:23'h000100, len:9'd4,   base:16'h0000, exp_grant:2'b01, exp_acks:4,   exp_cmd:1'b1, exp_done_cyc:5};
        vecs[1] = '{port:1'b1, we:1'b0, addr:23'h7FFFFF, len:9'd1,   base:16'hA000, exp_grant:2'b10, exp_acks:1,   exp_cmd:1'b1, exp_done_cyc:2};
        vecs[2] = '{port:1'b0, we:1'b0, addr:23'h000123, len:9'd3,   base:16'h5550, exp_grant:2'b01, exp_acks:3,   exp_cmd:1'b1, exp_done_cyc:4};
        vecs[3] = '{port:1'b1, we:1'b1, addr:23'h001234, len:9'd511, base:16'h8000, exp_grant:2'b10, exp_acks:511, exp_cmd:1'b1, exp_done_cyc:512};
        vecs[4] = '{port:1'b1, we:1'b0, addr:23'h0ABCDE, len:9'd0,   base:16'h1111, exp_grant:2'b10, exp_acks:0,   exp_cmd:1'b0, exp_done_cyc:1};
        vecs[5] = '{port:1'b0, we:1'b1, addr:23'h400000, len:9'd2,   base:16'hFFFE, exp_grant:2'b01, exp_acks:2,   exp_cmd:1'b1, exp_done_cyc:3};
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset values and init gating.
        reset_n = 1'b0;
        clearInputs();
        bus.sdram_init_done = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("reset_grant", grant, 2'b00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_cmd", {bus.sdram_wr_req, bus.sdram_rd_req}, 2'b00);
        checkOutput("reset_done", {bus.p1_done, bus.p0_done, timeout_err}, 3'b000);
        checkOutput("reset_addr", bus.sys_wraddr, 23'h0);

        setPort(1'b0, 1'b1, 1'b1, 23'h0002AA, 9'd1, 16'hBEEF);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (bus.sdram_wr_req || bus.sdram_rd_req || grant != 2'b00 || busy) viol++;
        end
        checkOutput("init_gate_violations", viol, 0);
        bus.sdram_init_done = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("init_req_after_1", bus.sdram_wr_req, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("init_req_after_2", bus.sdram_wr_req, 1'b1);
        checkOutput("init_grant", grant, 2'b01);
        checkOutput("init_wraddr", bus.sys_wraddr, 23'h0002AA);
        bus.sdram_wr_ack = 1'b1;
        #1;
        checkOutput("init_p0_ack", bus.p0_ack, 1'b1);
        checkOutput("init_sys_data_in", bus.sys_data_in, 16'hBEEF);
        @(negedge clk);
        #1;
        checkOutput("init_p0_done", bus.p0_done, 1'b1);
        bus.sdram_wr_ack = 1'b0;
        bus.p0_req = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("init_grant_cleared", grant, 2'b00);

        // Round-robin: both ports hold read requests, controller acks every cycle.
        doReset(1'b1);
        setPort(1'b0, 1'b1, 1'b0, 23'h000010, 9'd2, 16'h0);
        setPort(1'b1, 1'b1, 1'b0, 23'h000020, 9'd2, 16'h0);
        bus.sdram_rd_ack = 1'b1;
        rr = '{2'b00, 2'b00, 2'b00, 2'b00};
        n = 0;
        viol = 0;
        for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
            @(negedge clk);
            #1;
            if (grant == 2'b11) viol++;
            if (bus.p0_done || bus.p1_done) begin
                rr[n] = {bus.p1_done, bus.p0_done};
                n++;
                if (n == 4) begin
                    bus.p0_req = 1'b0;
                    bus.p1_req = 1'b0;
                end
            end
        end
        bus.sdram_rd_ack = 1'b0;
        checkOutput("rr_burst_count", n, 4);
        checkOutput("rr_overlap", viol, 0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_done_%0d", i), rr[i], exp_rr[i]);
        @(negedge clk);
        #1;
        checkOutput("rr_idle_after", {grant, busy}, 3'b000);

        // Ack timeout on port 0 read, port 1 waiting behind it.
        doReset(1'b1);
        setPort(1'b0, 1'b1, 1'b0, 23'h000055, 9'd4, 16'h0);
        setPort(1'b1, 1'b1, 1'b0, 23'h000066, 9'd1, 16'h0);
        hi = 0;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            @(negedge clk);
            #1;
            if (bus.sdram_rd_req) hi++;
            else if (hi > 0) break;
        end
        checkOutput("timeout_req_cycles", hi, 1024);
        checkOutput("timeout_err_pulse", timeout_err, 1'b1);
        checkOutput("timeout_p0_done", bus.p0_done, 1'b1);
        bus.p0_req = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("timeout_err_cleared", timeout_err, 1'b0);
        checkOutput("timeout_gap_grant", grant, 2'b00);
        @(negedge clk);
        #1;
        checkOutput("timeout_p1_grant", grant, 2'b10);
        checkOutput("timeout_p1_rdaddr", bus.sys_rdaddr, 23'h000066);
        bus.sys_data_out = 16'h7E57;
        bus.sdram_rd_ack = 1'b1;
        #1;
        checkOutput("timeout_p1_rdata", {bus.p1_ack, bus.p1_rdata}, {1'b1, 16'h7E57});
        @(negedge clk);
        #1;
        checkOutput("timeout_p1_done", bus.p1_done, 1'b1);
        bus.sdram_rd_ack = 1'b0;
        bus.p1_req = 1'b0;

        // Reset during a write burst after 3 of 8 words.
        doReset(1'b1);
        setPort(1'b0, 1'b1, 1'b1, 23'h0003C0, 9'd8, 16'h0);
        given = 0;
        for (int cyc = 0; cyc < 10 && given < 3; cyc++) begin
            @(negedge clk);
            if (bus.sdram_wr_req || given > 0) begin
                bus.sdram_wr_ack = 1'b1;
                bus.p0_wdata = 16'(given);
                given++;
            end
        end
        checkOutput("rst_acks_given", given, 3);
        @(negedge clk);
        bus.sdram_wr_ack = 1'b0;
        bus.p0_wdata = 16'h1234;
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_outputs", {grant, busy, timeout_err, bus.sdram_wr_req, bus.sdram_rd_req,
                                    bus.p0_done, bus.p1_done, bus.p0_ack}, 10'h0);
        checkOutput("rst_sys_data_in", bus.sys_data_in, 16'h0000);
        checkOutput("rst_sdwr_byte", bus.sdwr_byte, 9'd0);
        reset_n = 1'b1;
        bus.p0_req = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_no_done_after", {bus.p0_done, bus.p1_done, busy}, 3'b000);

        // Table of single-port bursts.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], r);
            checkOutput($sformatf("vec%0d_grant", i), r.g_seen, vecs[i].exp_grant);
            checkOutput($sformatf("vec%0d_acks", i), r.acks_seen, vecs[i].exp_acks);
            checkOutput($sformatf("vec%0d_done_cnt", i), r.done_cnt, 1);
            checkOutput($sformatf("vec%0d_done_cycle", i), r.done_cyc, vecs[i].exp_done_cyc);
            checkOutput($sformatf("vec%0d_cmd_seen", i), r.cmd_seen, vecs[i].exp_cmd);
            if (vecs[i].exp_cmd) begin
                checkOutput($sformatf("vec%0d_addr", i), r.addr_seen, vecs[i].addr);
                checkOutput($sformatf("vec%0d_len", i), r.len_seen, vecs[i].len);
            end
            checkOutput($sformatf("vec%0d_word_errs", i), r.errs, 0);
            checkOutput($sformatf("vec%0d_after", i), {r.grant_after, r.busy_after, r.done_after}, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
